migcorre_duty_ctrl: RTL
=======================

MIGCORRE_DUTY_CTRL -- requirements
Module: migcorre_duty_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 4, duty word width.
REQ-002 SHALL have parameter DUTY_RESET, default 8, duty value loaded at reset.
REQ-003 SHALL have parameter DEB_CYCLES, default 4, consecutive stable cycles required to accept a button level.
REQ-004 SHALL have parameter REPEAT_DELAY, default 16, hold cycles from first step to first auto-repeat step.
REQ-005 SHALL have parameter REPEAT_RATE, default 4, cycles between auto-repeat steps.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 inc_btn  input  1  raw asynchronous increase-duty button.
REQ-009 dec_btn  input  1  raw asynchronous decrease-duty button.
REQ-010 duty  output  DUTY_W  registered duty command to the PWM datapath.
REQ-011 duty_upd  output  1  one-cycle pulse in the cycle duty takes a new value.
REQ-012 at_max / at_min  output  1 each  registered flags, duty == 2^DUTY_W-1 / duty == 0.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer flipping its level only after DEB_CYCLES consecutive synchronized samples differing from the current debounced level; any agreeing sample clears the count.
REQ-014 For a raw input rising before edge 0 and held, the debounced level SHALL flip at edge 2+DEB_CYCLES and duty SHALL update at edge 3+DEB_CYCLES (cycle 7 at defaults).
REQ-015 Controller FSM states SHALL be IDLE, FIRST, HOLD, REPEAT, LOCK.
REQ-016 IDLE: exactly one debounced button high -> FIRST; both high -> LOCK.
REQ-017 FIRST: one step in button direction, hold counter cleared -> HOLD.
REQ-018 HOLD: counter increments per cycle; at REPEAT_DELAY-1 -> REPEAT with a step; button released -> IDLE.
REQ-019 REPEAT: one step every REPEAT_RATE cycles while held; release -> IDLE.
REQ-020 Any state with both debounced buttons high SHALL go to LOCK with no step; LOCK exits to IDLE only when both are low.
REQ-021 Step SHALL be +/-1, saturating at 0 and 2^DUTY_W-1; a step at a bound SHALL leave duty unchanged and SHALL NOT pulse duty_upd.
REQ-022 Direction is latched in FIRST; a swap of buttons without an intervening both-low or both-high cycle SHALL return to IDLE then re-enter FIRST.
REQ-023 at_max/at_min SHALL reflect the registered duty in the same cycle as duty.

Reset
REQ-024 Asserting reset_n low SHALL immediately force duty=DUTY_RESET, duty_upd=0, at_max/at_min per DUTY_RESET, FSM=IDLE, all counters, synchronizers and debounced levels=0, including mid-hold.
REQ-025 After reset_n deasserts, a button already held SHALL be treated as a new press (full debounce, then FIRST).

Structure
REQ-026 Shared package migcorre_pwm_pkg SHALL hold the FSM state typedef and default DUTY_W.
REQ-027 Synchronizer plus debouncer SHALL be sub-module migcorre_debounce (param DEB_CYCLES), instantiated once per button.
REQ-028 Target size 150-300 lines RTL, no combinational path from inputs to outputs.

Verification (defaults)
REQ-029 Reset with inputs low -> duty=8, duty_upd=0, at_max=0, at_min=0.
REQ-030 inc_btn high from cycle 0 for 12 cycles -> duty=9 at cycle 7, single duty_upd pulse, no further change.
REQ-031 inc_btn held 40 cycles -> duty steps at cycles 7, 23, 27, 31, 35, 39 (8->14).
REQ-032 duty=14, inc held 40 cycles -> 15, at_max=1, exactly one duty_upd; dec held similarly from 1 -> 0, at_min=1.
REQ-033 inc pulse 3 cycles wide -> no change; inc and dec rising same cycle -> LOCK, duty unchanged until both released.
REQ-034 reset_n low during REPEAT at duty=12 -> duty=8 asynchronously; button still held after release -> first step at 7 cycles after reset_n deasserts.

Source files
------------

// File: rtl/migcorre_pwm_pkg.sv
// Shared types and defaults for the PWM duty-command block.
package migcorre_pwm_pkg;

  localparam int unsigned DUTY_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_HOLD,
    ST_REPEAT,
    ST_LOCK
  } ctrl_state_e;

endpackage

// File: rtl/migcorre_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
module migcorre_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  // The level flips on the sample after DEB_CYCLES differing samples have
  // been counted, so a held press settles DEB_CYCLES+2 edges after it lands.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DEB_LIM) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/migcorre_duty_ctrl.sv
// Button-driven duty command: debounced inc/dec with hold-to-repeat and saturation.
module migcorre_duty_ctrl
  import migcorre_pwm_pkg::*;
#(
  parameter int unsigned DUTY_W       = DUTY_W_DEF,
  parameter int unsigned DUTY_RESET   = 8,
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc_btn,
  input  logic              dec_btn,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LIM = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LIM  = CW'(REPEAT_RATE);

  localparam logic [DUTY_W-1:0] DUTY_RST   = DUTY_W'(DUTY_RESET);
  localparam logic [DUTY_W-1:0] DUTY_MAX   = '1;
  localparam logic              RST_AT_MAX = (DUTY_RST == DUTY_MAX);
  localparam logic              RST_AT_MIN = (DUTY_RST == '0);

  logic inc_db, dec_db;

  migcorre_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (inc_btn),
    .level_o(inc_db)
  );

  migcorre_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (dec_btn),
    .level_o(dec_db)
  );

  ctrl_state_e       state_q, state_d;
  logic              dir_q, dir_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              upd_q, upd_d;
  logic              at_max_q, at_min_q;
  logic              step, step_dir, both, held;

  // The first step is issued on the IDLE->FIRST transition so the duty
  // register updates on the edge right after the debounced level rises.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    step     = 1'b0;
    step_dir = dir_q;
    both     = inc_db & dec_db;
    held     = dir_q ? inc_db : dec_db;
    cnt_inc  = cnt_q + CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (both) begin
          state_d = ST_LOCK;
        end else if (inc_db || dec_db) begin
          state_d  = ST_FIRST;
          dir_d    = inc_db;
          step     = 1'b1;
          step_dir = inc_db;
        end
      end
      ST_FIRST: begin
        if (both)       state_d = ST_LOCK;
        else if (!held) state_d = ST_IDLE;
        else begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (both)       state_d = ST_LOCK;
        else if (!held) state_d = ST_IDLE;
        else if (cnt_inc == DELAY_LIM) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
          step    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_REPEAT: begin
        if (both)       state_d = ST_LOCK;
        else if (!held) state_d = ST_IDLE;
        else if (cnt_inc == RATE_LIM) begin
          cnt_d = '0;
          step  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_LOCK: begin
        if (!inc_db && !dec_db) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    upd_d  = 1'b0;
    if (step) begin
      if (step_dir && (duty_q != DUTY_MAX)) begin
        duty_d = duty_q + DUTY_W'(1);
        upd_d  = 1'b1;
      end else if (!step_dir && (duty_q != '0)) begin
        duty_d = duty_q - DUTY_W'(1);
        upd_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      duty_q   <= DUTY_RST;
      upd_q    <= 1'b0;
      at_max_q <= RST_AT_MAX;
      at_min_q <= RST_AT_MIN;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      at_max_q <= (duty_d == DUTY_MAX);
      at_min_q <= (duty_d == '0);
    end
  end

  assign duty     = duty_q;
  assign duty_upd = upd_q;
  assign at_max   = at_max_q;
  assign at_min   = at_min_q;

endmodule
